// File: rtl/reg32_rr_arbiter.sv
// Round-robin write arbiter that shares one reg32 among NREQ requesters.
// Each grant becomes a one-cycle load pulse, then an ack with a read-back compare.
module reg32_rr_arbiter #(
    parameter  int NREQ = 4,
    parameter  int W    = 32,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   req_ack,
    output logic              wr_err,
    output logic              busy,
    output logic [IDW-1:0]    grant_id,
    output logic [W-1:0]      reg_d,
    output logic              reg_load,
    input  logic [W-1:0]      reg_q
);
    typedef enum logic [1:0] {IDLE, LOAD, CHECK} state_t;

    localparam int unsigned N = NREQ;

    state_t         state;
    state_t         state_nx;
    logic [IDW-1:0] rr_ptr;
    logic [W-1:0]   data_r;
    logic [W-1:0]   data_arr [NREQ];
    logic           found;
    logic           grant;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] ptr_nx;

    for (genvar g = 0; g < NREQ; g++) begin : g_split
        assign data_arr[g] = req_data[g*W +: W];
    end

    // Search starts at rr_ptr and wraps at NREQ, not at 2**IDW.
    always_comb begin
        int unsigned idx;
        int unsigned nxt;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req_valid[IDW'(idx)]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
        nxt = 32'(winner) + 1;
        if (nxt >= N) begin
            nxt = 0;
        end
        ptr_nx = IDW'(nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant    = 1'b1;
                    state_nx = LOAD;
                end
            end
            LOAD:    state_nx = CHECK;
            CHECK:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            grant_id <= '0;
            data_r   <= '0;
        end else if (grant) begin
            rr_ptr   <= ptr_nx;
            grant_id <= winner;
            data_r   <= data_arr[winner];
        end
    end

    always_comb begin
        reg_d    = data_r;
        reg_load = (state == LOAD);
        busy     = (state != IDLE);
        req_ack  = '0;
        wr_err   = 1'b0;
        if (state == CHECK) begin
            req_ack[grant_id] = 1'b1;
            wr_err            = (reg_q != data_r);
        end
    end

endmodule

// File: tb/tb_reg32_rr_arbiter.sv
// Bench for reg32_rr_arbiter: directed scenarios plus random traffic against a
// transaction-level model, with a behavioural reg32 standing in for the shared register.
`timescale 1ns/1ps
module tb_reg32_rr_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int IDW  = 2;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ack;
    logic              wr_err;
    logic              busy;
    logic [IDW-1:0]    grant_id;
    logic [W-1:0]      reg_d;
    logic              reg_load;
    logic [W-1:0]      reg_q;

    logic [W-1:0]      dat [NREQ];
    logic [W-1:0]      q_store;
    logic              bad_q;
    logic [NREQ-1:0]   keep;
    int                cyc = 0;
    int                n_cmp = 0;
    int                n_bad = 0;

    reg32_rr_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ack(req_ack), .wr_err(wr_err), .busy(busy), .grant_id(grant_id),
        .reg_d(reg_d), .reg_load(reg_load), .reg_q(reg_q)
    );

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign req_data[g*W +: W] = dat[g];
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared register stand-in; bad_q corrupts the read-back path.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        q_store <= '0;
        else if (reg_load) q_store <= reg_d;
    end
    assign reg_q = bad_q ? 32'hDEAD_BEEF : q_store;

    // Transaction model: m_left counts cycles remaining in the current write.
    int           m_left;
    int           m_ptr;
    int           m_gid;
    logic [W-1:0] m_data;
    logic [W-1:0] m_q;

    function automatic int pick(logic [NREQ-1:0] v, int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0; m_ptr <= 0; m_gid <= 0; m_data <= '0; m_q <= '0;
        end else begin
            if (m_left == 2) m_q <= m_data;
            if (m_left > 0) begin
                m_left <= m_left - 1;
            end else if (pick(req_valid, m_ptr) >= 0) begin
                m_left <= 2;
                m_gid  <= pick(req_valid, m_ptr);
                m_data <= dat[pick(req_valid, m_ptr)];
                m_ptr  <= (pick(req_valid, m_ptr) + 1) % NREQ;
            end
        end
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct { int cyc; int idx; logic err; logic [W-1:0] q; } ack_t;
    typedef struct { int cyc; logic [W-1:0] d; } ld_t;
    ack_t ack_log[$];
    ld_t  ld_log[$];

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_ack;
        logic [W-1:0]    q_seen;
        ack_t            a;
        ld_t             l;
        exp_ack = (m_left == 1) ? NREQ'(1) << m_gid : '0;
        q_seen  = bad_q ? 32'hDEAD_BEEF : m_q;
        chk("reg_load", 64'(reg_load), 64'(m_left == 2));
        chk("reg_d",    64'(reg_d),    64'(m_data));
        chk("req_ack",  64'(req_ack),  64'(exp_ack));
        chk("wr_err",   64'(wr_err),   64'((m_left == 1) && (q_seen != m_data)));
        chk("busy",     64'(busy),     64'(m_left != 0));
        chk("grant_id", 64'(grant_id), 64'(m_gid));
        if (reg_load) begin
            l.cyc = cyc; l.d = reg_d;
            ld_log.push_back(l);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (req_ack[i]) begin
                a.cyc = cyc; a.idx = i; a.err = wr_err; a.q = reg_q;
                ack_log.push_back(a);
            end
        end
    end

    // One cycle; a requester drops valid at the edge closing its ack unless kept.
    task automatic step();
        logic [NREQ-1:0] a;
        @(negedge clk);
        a = req_ack;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~(a & ~keep);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        keep = '0;
        bad_q = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int c0;
    int exp_seq [5] = '{0, 1, 2, 3, 0};

    initial begin
        for (int i = 0; i < NREQ; i++) dat[i] = $urandom;
        keep = '0;
        bad_q = 1'b0;
        req_valid = '1;

        // Reset held with every requester pending
        repeat (2) @(negedge clk);
        chk("rst_load", 64'(reg_load), 64'd0);
        chk("rst_ack",  64'(req_ack),  64'd0);
        chk("rst_busy", 64'(busy),     64'd0);
        chk("rst_gid",  64'(grant_id), 64'd0);
        chk("rst_q",    64'(reg_q),    64'd0);

        // Single write on requester 2
        do_reset();
        dat[2] = 32'hA5A5_A5A5;
        req_valid = 4'b0100;
        c0 = cyc;
        ld_log.delete(); ack_log.delete();
        repeat (4) step();
        chk("t2_nload", 64'(ld_log.size()), 64'd1);
        chk("t2_nack",  64'(ack_log.size()), 64'd1);
        if (ld_log.size() == 1) begin
            chk("t2_ldcyc", 64'(ld_log[0].cyc), 64'(c0 + 1));
            chk("t2_ld_d",  64'(ld_log[0].d),   64'h0000_0000_A5A5_A5A5);
        end
        if (ack_log.size() == 1) begin
            chk("t2_ackcyc", 64'(ack_log[0].cyc), 64'(c0 + 2));
            chk("t2_ackidx", 64'(ack_log[0].idx), 64'd2);
            chk("t2_err",    64'(ack_log[0].err), 64'd0);
            chk("t2_q",      64'(ack_log[0].q),   64'h0000_0000_A5A5_A5A5);
        end

        // Round robin with all four held valid
        do_reset();
        for (int i = 0; i < NREQ; i++) dat[i] = W'(32'h1111_1111 * (i + 1));
        req_valid = '1;
        keep = '1;
        c0 = cyc;
        ack_log.delete();
        repeat (15) step();
        keep = '0;
        req_valid = '0;
        repeat (3) step();
        chk("t3_nack", 64'(ack_log.size()), 64'd5);
        for (int k = 0; k < 5 && k < ack_log.size(); k++) begin
            chk("t3_idx", 64'(ack_log[k].idx), 64'(exp_seq[k]));
            chk("t3_cyc", 64'(ack_log[k].cyc), 64'(c0 + 2 + 3 * k));
            chk("t3_q",   64'(ack_log[k].q),   64'(32'h1111_1111 * (exp_seq[k] + 1)));
        end

        // Pointer wraps past 3 to 0: requests on 1 and 3 give 1 first
        do_reset();
        dat[3] = $urandom;
        req_valid = 4'b1000;
        repeat (4) step();
        req_valid = 4'b1010;
        c0 = cyc;
        ack_log.delete();
        repeat (7) step();
        chk("t4_nack", 64'(ack_log.size()), 64'd2);
        if (ack_log.size() == 2) begin
            chk("t4_first",  64'(ack_log[0].idx), 64'd1);
            chk("t4_second", 64'(ack_log[1].idx), 64'd3);
            chk("t4_cyc",    64'(ack_log[1].cyc), 64'(c0 + 5));
        end

        // Corrupted read-back
        do_reset();
        bad_q = 1'b1;
        dat[0] = 32'h1234_5678;
        req_valid = 4'b0001;
        ack_log.delete();
        repeat (4) step();
        bad_q = 1'b0;
        chk("t5_nack", 64'(ack_log.size()), 64'd1);
        if (ack_log.size() == 1) begin
            chk("t5_idx", 64'(ack_log[0].idx), 64'd0);
            chk("t5_err", 64'(ack_log[0].err), 64'd1);
        end

        // Reset during LOAD aborts the write and rewinds the pointer
        do_reset();
        dat[1] = $urandom;
        dat[2] = $urandom;
        req_valid = 4'b0110;
        keep = '1;
        step();
        #1;
        chk("t6_inload", 64'(reg_load), 64'd1);
        chk("t6_gid",    64'(grant_id), 64'd1);
        rst_n = 1'b0;
        ack_log.delete();
        #1;
        chk("t6_load0", 64'(reg_load), 64'd0);
        chk("t6_busy0", 64'(busy),     64'd0);
        chk("t6_gid0",  64'(grant_id), 64'd0);
        chk("t6_d0",    64'(reg_d),    64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("t6_noack", 64'(ack_log.size()), 64'd0);
        rst_n = 1'b1;
        repeat (3) step();
        chk("t6_nack", 64'(ack_log.size()), 64'd1);
        if (ack_log.size() >= 1) chk("t6_regrant", 64'(ack_log[0].idx), 64'd1);

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    dat[i] = $urandom;
                end
            end
            keep  = NREQ'($urandom);
            bad_q = ($urandom_range(0, 7) == 0);
            if (m_left > 0 && $urandom_range(0, 3) == 0) dat[m_gid] = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
